replacement_request_sequencer: RTL and testbench
================================================

Name: replacement_request_sequencer

Overview:
- Master-side driver of the replacement-algorithm interface (access/invalidate/replacement-line signals) for a set-associative cache.
- Sits between the cache controller's CPU and snoop paths and a set-associative LRU bank.
- Sequences hit updates, miss victim selection with the fill handshake, and buffered snoop invalidations.

Parameters:
INDEX_WIDTH, 6, set index width.
NUMBER_OF_CACHE_LINES, 4, ways per set; power of two, at least 2.
COUNTER_WIDTH, $clog2(NUMBER_OF_CACHE_LINES), way-select width.

Ports:
clock  in  1  single clock.
reset  in  1  synchronous, active-high.
cpuRequest  in  1  CPU lookup valid; accepted when cpuReady=1.
cpuIndex  in  INDEX_WIDTH  set of the lookup.
cpuHit  in  1  lookup hit.
cpuHitLine  in  COUNTER_WIDTH  way that hit.
cpuReady  out  1  high only in IDLE.
cpuDone  out  1  one-cycle completion pulse.
victimValid  out  1  victim presented; held until fillDone.
victimLine  out  COUNTER_WIDTH  way to refill.
fillDone  in  1  controller finished the refill; sampled only in VICTIM.
lineValids  in  NUMBER_OF_CACHE_LINES  valid bits of set cpuIndexOut (used only with the optional feature).
snoopValid  in  1  invalidate request; pushed when snoopReady=1.
snoopIndex  in  INDEX_WIDTH  snooped set.
snoopLine  in  COUNTER_WIDTH  snooped way.
snoopReady  out  1  ~fifoFull.
cpuIndexOut  out  INDEX_WIDTH  registered set index to the LRU bank.
accessEnable  out  1  registered one-cycle access pulse.
lastAccessedCacheLine  out  COUNTER_WIDTH  way accessed.
replacementCacheLine  in  COUNTER_WIDTH  LRU way of set cpuIndexOut.
snoopyIndexOut  out  INDEX_WIDTH  registered snooped set.
invalidateEnable  out  1  registered one-cycle invalidate pulse.
invalidatedCacheLine  out  COUNTER_WIDTH  way invalidated.

Behaviour:
- Reset: all outputs 0 except cpuReady=1 and snoopReady=1. State is IDLE, FIFO is empty.
- Reset mid-operation abandons the miss or fill in progress and drops buffered snoops. No pulse is emitted in the reset cycle.
- FSM states: IDLE, HIT_UPDATE, LOOKUP, VICTIM, MISS_UPDATE.
- IDLE: on cpuRequest, capture cpuIndex into cpuIndexOut.
  - If cpuHit: go to HIT_UPDATE.
  - Otherwise: go to LOOKUP.
- HIT_UPDATE (1 cycle):
  - accessEnable=1, lastAccessedCacheLine=cpuHitLine captured at acceptance, cpuDone=1.
  - Next state IDLE.
  - Latency: accept at cycle N, pulse at N+1, cpuReady again at N+2.
- LOOKUP (1 cycle):
  - cpuIndexOut is stable; replacementCacheLine is sampled into victimLine at the end of the cycle.
  - Next state VICTIM.
  - A snoop invalidate of the same set in this cycle does not alter the sample.
- VICTIM:
  - victimValid=1; victimLine held stable.
  - Stays until fillDone=1, then goes to MISS_UPDATE.
  - fillDone in the first VICTIM cycle is legal.
- MISS_UPDATE (1 cycle):
  - accessEnable=1, lastAccessedCacheLine=victimLine, cpuDone=1, victimValid=0.
  - Next state IDLE.
  - Minimum miss latency: accept N, LOOKUP N+1, VICTIM N+2, fillDone at N+2 gives the pulse at N+3.
- cpuIndexOut holds its last value in IDLE. accessEnable is 0 in every state except HIT_UPDATE and MISS_UPDATE.
- Snoop path, independent of the FSM:
  - 2-entry FIFO of {index,line}.
  - Push when snoopValid & snoopReady. Pop whenever non-empty, one entry per cycle.
  - Popped entry drives invalidateEnable=1, snoopyIndexOut and invalidatedCacheLine on the next cycle.
  - Push into an empty FIFO at N gives the pulse at N+1. Back-to-back pushes give back-to-back pulses.
  - When full, snoopReady=0 even if a pop occurs in the same cycle; the request is not lost because the producer holds it.
- Simultaneous accessEnable and invalidateEnable, same or different set, are both issued unchanged; ordering inside the LRU is its own concern.
- Protocol errors: cpuRequest outside IDLE and fillDone outside VICTIM are ignored.

Optional Feature:
- Macro: REPLACEMENT_INVALID_FIRST_EN.
- Defined:
  - At the end of LOOKUP, if any lineValids bit is 0, victimLine is the lowest-numbered invalid way.
  - Otherwise victimLine is replacementCacheLine.
- Undefined: lineValids is unused and victimLine is always replacementCacheLine. Port list is identical in both builds.

Decomposition:
- Package replacement_sequencer_pkg holds:
  - the FSM state enum;
  - the snoop entry struct typedef;
  - a helper function that finds the lowest zero bit of a vector.
- One sub-module, snoop_invalidate_fifo: 2-entry FIFO with registered output pulse, parameterized by INDEX_WIDTH and COUNTER_WIDTH.

Test Plan:
- Hit: cpuRequest, cpuIndex=5, cpuHit=1, cpuHitLine=2 at N -> accessEnable=1, cpuIndexOut=5, lastAccessedCacheLine=2, cpuDone=1 at N+1 only; cpuReady=1 at N+2.
- Miss: cpuIndex=9, cpuHit=0, LRU returns 3 -> victimValid=1, victimLine=3 from N+2. Hold fillDone=0 for 4 cycles, then fillDone=1 -> accessEnable=1, lastAccessedCacheLine=3, cpuDone=1 the cycle after.
- Snoop burst: snoopValid for 3 consecutive cycles (idx 1/2/3, line 0/1/2) -> invalidateEnable pulses on consecutive cycles with matching values; snoopReady stays 1, since the FIFO never exceeds 1 entry.
- Concurrency: a snoop to set 9 during LOOKUP of the set-9 miss -> invalidate is issued, victimLine equals the value sampled in LOOKUP, and the miss completes normally.
- Reset while in VICTIM -> the next cycle has all outputs 0, cpuReady=1, no accessEnable pulse, and the FIFO is empty.
- With REPLACEMENT_INVALID_FIRST_EN: lineValids=4'b1011, LRU returns 0 -> victimLine=2. Without the macro: victimLine=0.

Source files
------------

// File: rtl/replacement_request_sequencer_pkg.sv
// replacement_sequencer_pkg: shared FSM states, snoop entry type and victim helper.
package replacement_sequencer_pkg;
    localparam int SNOOP_INDEX_WIDTH = 6;
    localparam int SNOOP_LINE_WIDTH = 2;

    typedef enum logic [2:0] {IDLE, HIT_UPDATE, LOOKUP, VICTIM, MISS_UPDATE} state_t;

    typedef struct packed {
        logic [SNOOP_INDEX_WIDTH-1:0] index;
        logic [SNOOP_LINE_WIDTH-1:0]  line;
    } snoop_entry_t;

    // Position of the lowest zero among the first n bits of v (0 when none).
    function automatic int lowest_zero(input logic [31:0] v, input int n);
        int r;
        r = 0;
        for (int i = n - 1; i >= 0; i--)
            if (!v[i]) r = i;
        return r;
    endfunction
endpackage

// File: rtl/replacement_request_sequencer_snoop_fifo.sv
// snoop_invalidate_fifo: 2-entry snoop buffer; the head entry drives the invalidate pulse
// straight from registers and is retired in the same cycle.
module snoop_invalidate_fifo
    import replacement_sequencer_pkg::*;
#(
    parameter int INDEX_WIDTH   = SNOOP_INDEX_WIDTH,
    parameter int COUNTER_WIDTH = SNOOP_LINE_WIDTH
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     i_valid,
    input  logic [INDEX_WIDTH-1:0]   i_index,
    input  logic [COUNTER_WIDTH-1:0] i_line,
    output logic                     o_ready,
    output logic                     o_invalidate,
    output logic [INDEX_WIDTH-1:0]   o_index,
    output logic [COUNTER_WIDTH-1:0] o_line
);
    snoop_entry_t r_mem [2];
    logic [1:0]   r_count;
    logic         r_rd;
    logic         r_wr;
    logic         w_push;
    logic         w_pop;

    assign o_ready      = r_count != 2'd2;
    assign w_push       = i_valid && o_ready;
    assign w_pop        = r_count != 2'd0;
    assign o_invalidate = w_pop;
    assign o_index      = w_pop ? INDEX_WIDTH'(r_mem[r_rd].index) : '0;
    assign o_line       = w_pop ? COUNTER_WIDTH'(r_mem[r_rd].line) : '0;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_count <= '0;
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
        end else begin
            if (w_push)
                r_mem[r_wr] <= '{index: SNOOP_INDEX_WIDTH'(i_index), line: SNOOP_LINE_WIDTH'(i_line)};
            r_wr    <= r_wr ^ w_push;
            r_rd    <= r_rd ^ w_pop;
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end
endmodule

// File: rtl/replacement_request_sequencer.sv
// replacement_request_sequencer: drives access/invalidate requests into a set-associative LRU bank.
// Define REPLACEMENT_INVALID_FIRST_EN to prefer the lowest invalid way as the miss victim.
module replacement_request_sequencer
    import replacement_sequencer_pkg::*;
#(
    parameter int INDEX_WIDTH           = SNOOP_INDEX_WIDTH,
    parameter int NUMBER_OF_CACHE_LINES = 4,
    parameter int COUNTER_WIDTH         = $clog2(NUMBER_OF_CACHE_LINES)
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             cpuRequest,
    input  logic [INDEX_WIDTH-1:0]           cpuIndex,
    input  logic                             cpuHit,
    input  logic [COUNTER_WIDTH-1:0]         cpuHitLine,
    output logic                             cpuReady,
    output logic                             cpuDone,
    output logic                             victimValid,
    output logic [COUNTER_WIDTH-1:0]         victimLine,
    input  logic                             fillDone,
    input  logic [NUMBER_OF_CACHE_LINES-1:0] lineValids,
    input  logic                             snoopValid,
    input  logic [INDEX_WIDTH-1:0]           snoopIndex,
    input  logic [COUNTER_WIDTH-1:0]         snoopLine,
    output logic                             snoopReady,
    output logic [INDEX_WIDTH-1:0]           cpuIndexOut,
    output logic                             accessEnable,
    output logic [COUNTER_WIDTH-1:0]         lastAccessedCacheLine,
    input  logic [COUNTER_WIDTH-1:0]         replacementCacheLine,
    output logic [INDEX_WIDTH-1:0]           snoopyIndexOut,
    output logic                             invalidateEnable,
    output logic [COUNTER_WIDTH-1:0]         invalidatedCacheLine
);
    state_t                   r_state;
    state_t                   w_next;
    logic [COUNTER_WIDTH-1:0] r_hit_line;
    logic [COUNTER_WIDTH-1:0] r_victim;
    logic [COUNTER_WIDTH-1:0] w_victim;

`ifdef REPLACEMENT_INVALID_FIRST_EN
    assign w_victim = &lineValids ? replacementCacheLine
                    : COUNTER_WIDTH'(lowest_zero(32'(lineValids), NUMBER_OF_CACHE_LINES));
`else
    logic w_unused_line_valids;
    assign w_unused_line_valids = ^lineValids;
    assign w_victim = replacementCacheLine;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= IDLE;
            cpuIndexOut <= '0;
            r_hit_line  <= '0;
            r_victim    <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && cpuRequest) begin
                cpuIndexOut <= cpuIndex;
                r_hit_line  <= cpuHitLine;
            end
            if (r_state == LOOKUP)
                r_victim <= w_victim;
        end
    end

    always_comb begin
        w_next = IDLE;
        case (r_state)
            IDLE:    w_next = cpuRequest ? (cpuHit ? HIT_UPDATE : LOOKUP) : IDLE;
            LOOKUP:  w_next = VICTIM;
            VICTIM:  w_next = fillDone ? MISS_UPDATE : VICTIM;
            default: w_next = IDLE;
        endcase
    end

    assign cpuReady              = r_state == IDLE;
    assign accessEnable          = r_state == HIT_UPDATE || r_state == MISS_UPDATE;
    assign cpuDone               = accessEnable;
    assign victimValid           = r_state == VICTIM;
    assign victimLine            = r_victim;
    assign lastAccessedCacheLine = r_state == HIT_UPDATE ? r_hit_line
                                 : r_state == MISS_UPDATE ? r_victim : '0;

    snoop_invalidate_fifo #(
        .INDEX_WIDTH  (INDEX_WIDTH),
        .COUNTER_WIDTH(COUNTER_WIDTH)
    ) u_snoop_fifo (
        .clock       (clock),
        .reset       (reset),
        .i_valid     (snoopValid),
        .i_index     (snoopIndex),
        .i_line      (snoopLine),
        .o_ready     (snoopReady),
        .o_invalidate(invalidateEnable),
        .o_index     (snoopyIndexOut),
        .o_line      (invalidatedCacheLine)
    );
endmodule

// File: tb/tb_replacement_request_sequencer.sv
// tb_replacement_request_sequencer: randomized scoreboard bench; expected pulses are queued by
// the drivers and matched by a negedge monitor.
module tb_replacement_request_sequencer;
    logic       clock = 1'b0;
    logic       reset;
    logic       cpuRequest;
    logic [5:0] cpuIndex;
    logic       cpuHit;
    logic [1:0] cpuHitLine;
    logic       cpuReady;
    logic       cpuDone;
    logic       victimValid;
    logic [1:0] victimLine;
    logic       fillDone;
    logic [3:0] lineValids;
    logic       snoopValid;
    logic [5:0] snoopIndex;
    logic [1:0] snoopLine;
    logic       snoopReady;
    logic [5:0] cpuIndexOut;
    logic       accessEnable;
    logic [1:0] lastAccessedCacheLine;
    logic [1:0] replacementCacheLine;
    logic [5:0] snoopyIndexOut;
    logic       invalidateEnable;
    logic [1:0] invalidatedCacheLine;

    typedef struct {
        int         c;
        logic [5:0] idx;
        logic [1:0] line;
    } exp_t;

    exp_t       acc_q[$];
    exp_t       inv_q[$];
    logic [1:0] lru_table [64];
    logic [3:0] valid_table [64];
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    bit         mon_en = 1'b0;

    assign replacementCacheLine = lru_table[cpuIndexOut];
    assign lineValids = valid_table[cpuIndexOut];

    replacement_request_sequencer dut (
        .clock(clock), .reset(reset),
        .cpuRequest(cpuRequest), .cpuIndex(cpuIndex), .cpuHit(cpuHit), .cpuHitLine(cpuHitLine),
        .cpuReady(cpuReady), .cpuDone(cpuDone), .victimValid(victimValid), .victimLine(victimLine),
        .fillDone(fillDone), .lineValids(lineValids),
        .snoopValid(snoopValid), .snoopIndex(snoopIndex), .snoopLine(snoopLine), .snoopReady(snoopReady),
        .cpuIndexOut(cpuIndexOut), .accessEnable(accessEnable),
        .lastAccessedCacheLine(lastAccessedCacheLine), .replacementCacheLine(replacementCacheLine),
        .snoopyIndexOut(snoopyIndexOut), .invalidateEnable(invalidateEnable),
        .invalidatedCacheLine(invalidatedCacheLine)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Victim the LRU bank plus valid bits should yield for a given set.
    function automatic logic [1:0] exp_victim(input logic [5:0] idx);
`ifdef REPLACEMENT_INVALID_FIRST_EN
        for (int w = 0; w < 4; w++)
            if (!valid_table[idx][w]) return 2'(w);
`endif
        return lru_table[idx];
    endfunction

    always @(negedge clock) begin
        bit   ea;
        bit   ei;
        exp_t e;
        if (mon_en) begin
            ea = acc_q.size() > 0 && acc_q[0].c == cyc;
            if (ea || accessEnable) begin
                check("access_pulse", accessEnable, ea);
                check("cpu_done", cpuDone, ea);
                if (ea) begin
                    e = acc_q.pop_front();
                    if (accessEnable) begin
                        check("access_index", cpuIndexOut, e.idx);
                        check("access_line", lastAccessedCacheLine, e.line);
                    end
                end
            end
            ei = inv_q.size() > 0 && inv_q[0].c == cyc;
            if (ei || invalidateEnable) begin
                check("invalidate_pulse", invalidateEnable, ei);
                if (ei) begin
                    e = inv_q.pop_front();
                    if (invalidateEnable) begin
                        check("invalidate_index", snoopyIndexOut, e.idx);
                        check("invalidate_line", invalidatedCacheLine, e.line);
                    end
                end
            end
        end
    end

    task automatic snoop_push(input logic [5:0] idx, input logic [1:0] line);
        int   pending;
        exp_t e;
        pending = 0;
        foreach (inv_q[i]) if (inv_q[i].c >= cyc) pending++;
        check("snoop_ready", snoopReady, pending < 2);
        snoopValid = 1'b1;
        snoopIndex = idx;
        snoopLine = line;
        if (snoopReady) begin
            e.c = (inv_q.size() > 0 && inv_q[$].c >= cyc + 1) ? inv_q[$].c + 1 : cyc + 1;
            e.idx = idx;
            e.line = line;
            inv_q.push_back(e);
        end
        @(posedge clock); #1;
        snoopValid = 1'b0;
    endtask

    task automatic do_cpu(input logic [5:0] idx, input logic hit, input logic [1:0] hl,
                          input int fdelay, input logic early_fill);
        int         n;
        logic [1:0] v;
        exp_t       e;
        n = 0;
        while (!cpuReady && n < 50) begin
            @(posedge clock); #1;
            n++;
        end
        check("cpu_ready_wait", cpuReady, 1);
        cpuRequest = 1'b1;
        cpuIndex = idx;
        cpuHit = hit;
        cpuHitLine = hl;
        fillDone = 1'($urandom_range(1));
        if (hit) begin
            e.c = cyc + 1;
            e.idx = idx;
            e.line = hl;
            acc_q.push_back(e);
        end
        @(posedge clock); #1;
        cpuRequest = 1'($urandom_range(1));
        cpuIndex = 6'($urandom);
        cpuHit = 1'($urandom_range(1));
        fillDone = hit ? 1'($urandom_range(1)) : early_fill;
        check("cpu_ready_busy", cpuReady, 0);
        @(posedge clock); #1;
        cpuRequest = 1'b0;
        fillDone = 1'b0;
        if (hit) begin
            check("cpu_ready_after_hit", cpuReady, 1);
        end else begin
            v = exp_victim(idx);
            for (int i = 0; i < fdelay; i++) begin
                check("victim_valid_wait", victimValid, 1);
                check("victim_line_wait", victimLine, v);
                @(posedge clock); #1;
            end
            check("victim_valid", victimValid, 1);
            check("victim_line", victimLine, v);
            fillDone = 1'b1;
            e.c = cyc + 1;
            e.idx = idx;
            e.line = v;
            acc_q.push_back(e);
            @(posedge clock); #1;
            fillDone = 1'b0;
            check("victim_valid_drop", victimValid, 0);
            @(posedge clock); #1;
            check("cpu_ready_after_miss", cpuReady, 1);
        end
    endtask

    initial begin
        reset = 1'b1;
        cpuRequest = 1'b0;
        cpuIndex = '0;
        cpuHit = 1'b0;
        cpuHitLine = '0;
        fillDone = 1'b0;
        snoopValid = 1'b0;
        snoopIndex = '0;
        snoopLine = '0;
        for (int i = 0; i < 64; i++) begin
            lru_table[i] = 2'($urandom);
            valid_table[i] = ($urandom_range(3) == 0) ? 4'($urandom) : 4'hF;
        end
        lru_table[9] = 2'd3;
        valid_table[9] = 4'hF;
        lru_table[12] = 2'd0;
        valid_table[12] = 4'b1011;
        repeat (3) @(posedge clock);
        #1;
        check("rst_cpu_ready", cpuReady, 1);
        check("rst_snoop_ready", snoopReady, 1);
        check("rst_outputs", {cpuDone, victimValid, victimLine, cpuIndexOut, accessEnable,
              lastAccessedCacheLine, snoopyIndexOut, invalidateEnable, invalidatedCacheLine}, 0);
        reset = 1'b0;
        mon_en = 1'b1;
        @(posedge clock); #1;

        do_cpu(6'd5, 1'b1, 2'd2, 0, 1'b0);
        do_cpu(6'd9, 1'b0, 2'd0, 4, 1'b0);
        do_cpu(6'd12, 1'b0, 2'd0, 0, 1'b1);
        snoop_push(6'd1, 2'd0);
        snoop_push(6'd2, 2'd1);
        snoop_push(6'd3, 2'd2);
        fork
            do_cpu(6'd9, 1'b0, 2'd0, 2, 1'b0);
            begin
                @(posedge clock); #1;
                snoop_push(6'd9, 2'd3);
            end
        join
        repeat (3) @(posedge clock);
        #1;

        cpuRequest = 1'b1;
        cpuIndex = 6'd20;
        cpuHit = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        cpuRequest = 1'b0;
        check("pre_reset_victim", victimValid, 1);
        reset = 1'b1;
        snoopValid = 1'b1;
        snoopIndex = 6'd7;
        snoopLine = 2'd1;
        @(posedge clock); #1;
        reset = 1'b0;
        snoopValid = 1'b0;
        check("mid_rst_cpu_ready", cpuReady, 1);
        check("mid_rst_snoop_ready", snoopReady, 1);
        check("mid_rst_outputs", {cpuDone, victimValid, victimLine, cpuIndexOut, accessEnable,
              lastAccessedCacheLine, snoopyIndexOut, invalidateEnable, invalidatedCacheLine}, 0);
        @(posedge clock); #1;
        check("mid_rst_fifo_empty", invalidateEnable, 0);

        fork
            for (int t = 0; t < 40; t++) begin
                do_cpu(6'($urandom), 1'($urandom_range(1)), 2'($urandom),
                       int'($urandom_range(3)), 1'($urandom_range(1)));
                repeat ($urandom_range(2)) begin
                    @(posedge clock); #1;
                end
            end
            for (int t = 0; t < 200; t++) begin
                if ($urandom_range(2) != 0) snoop_push(6'($urandom), 2'($urandom));
                else begin
                    @(posedge clock); #1;
                end
            end
        join

        repeat (5) @(posedge clock);
        #1;
        check("acc_queue_drained", acc_q.size(), 0);
        check("inv_queue_drained", inv_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
